// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - dual-issue instruction queue between fetch and decode
// Accepts up to two {inst, pc} words per cycle and presents the two oldest to decode.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        fifo_empty,
    output logic        almost_empty,
    output logic        fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ZERO  = '0;
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);
    localparam logic [AW:0] L_TWO   = (AW+1)'(2);

    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_addr_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [AW:0]   w_free;
    logic [AW:0]   w_wr_req;
    logic [AW:0]   w_rd_req;
    logic [AW:0]   w_wr_num;
    logic [AW:0]   w_rd_num;
    logic [AW-1:0] w_wptr_p1;
    logic [AW-1:0] w_rptr_p1;

    // Slot 2 only counts alongside slot 1; both grants are capped by pre-edge state.
    always_comb begin
        w_free    = L_DEPTH - r_count;
        w_wr_req  = write_en1 ? (write_en2 ? L_TWO : L_ONE) : L_ZERO;
        w_rd_req  = read_en1  ? (read_en2  ? L_TWO : L_ONE) : L_ZERO;
        w_wr_num  = (w_wr_req > w_free)  ? w_free  : w_wr_req;
        w_rd_num  = (w_rd_req > r_count) ? r_count : w_rd_req;
        w_wptr_p1 = r_wptr + AW'(1);
        w_rptr_p1 = r_rptr + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + w_wr_num[AW-1:0];
            r_rptr  <= r_rptr + w_rd_num[AW-1:0];
            r_count <= r_count + w_wr_num - w_rd_num;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (w_wr_num != L_ZERO) begin
                r_inst_mem[r_wptr] <= write_inst1;
                r_addr_mem[r_wptr] <= write_addr1;
            end
            if (w_wr_num == L_TWO) begin
                r_inst_mem[w_wptr_p1] <= write_inst2;
                r_addr_mem[w_wptr_p1] <= write_addr2;
            end
        end
    end

    assign read_inst1   = (r_count >= L_ONE) ? r_inst_mem[r_rptr]    : 32'd0;
    assign read_addr1   = (r_count >= L_ONE) ? r_addr_mem[r_rptr]    : 32'd0;
    assign read_inst2   = (r_count >= L_TWO) ? r_inst_mem[w_rptr_p1] : 32'd0;
    assign read_addr2   = (r_count >= L_TWO) ? r_addr_mem[w_rptr_p1] : 32'd0;
    assign fifo_empty   = (r_count == L_ZERO);
    assign almost_empty = (r_count == L_ONE);
    assign fifo_full    = (r_count > (L_DEPTH - L_TWO));
endmodule

// File: tb/tb_inst_fifo.sv
// tb/tb_inst_fifo.sv - directed scoreboard bench for inst_fifo
// A queue of expected {inst, pc} entries predicts every output at each negedge.
module tb_inst_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        write_en1 = 1'b0, write_en2 = 1'b0;
    logic [31:0] write_inst1 = '0, write_inst2 = '0, write_addr1 = '0, write_addr2 = '0;
    logic        read_en1 = 1'b0, read_en2 = 1'b0;
    logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
    logic        fifo_empty, almost_empty, fifo_full;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_inst1(write_inst1), .write_inst2(write_inst2),
        .write_addr1(write_addr1), .write_addr2(write_addr2),
        .read_en1(read_en1), .read_en2(read_en2),
        .read_inst1(read_inst1), .read_inst2(read_inst2),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .fifo_empty(fifo_empty), .almost_empty(almost_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [31:0] e_i1, e_a1, e_i2, e_a2;
        n    = sb.size();
        e_i1 = (n >= 1) ? sb[0][63:32] : 32'd0;
        e_a1 = (n >= 1) ? sb[0][31:0]  : 32'd0;
        e_i2 = (n >= 2) ? sb[1][63:32] : 32'd0;
        e_a2 = (n >= 2) ? sb[1][31:0]  : 32'd0;
        chk({tag, ".empty"},  {31'd0, fifo_empty},   {31'd0, n == 0});
        chk({tag, ".aempty"}, {31'd0, almost_empty}, {31'd0, n == 1});
        chk({tag, ".full"},   {31'd0, fifo_full},    {31'd0, n > DEPTH - 2});
        chk({tag, ".inst1"},  read_inst1, e_i1);
        chk({tag, ".addr1"},  read_addr1, e_a1);
        chk({tag, ".inst2"},  read_inst2, e_i2);
        chk({tag, ".addr2"},  read_addr2, e_a2);
    endtask

    // Drive one cycle from a negedge, update the scoreboard, check at the next negedge.
    task automatic step(input string tag, input logic w1, input logic w2,
                        input logic [31:0] i1, input logic [31:0] a1,
                        input logic [31:0] i2, input logic [31:0] a2,
                        input logic r1, input logic r2, input logic fl);
        int n, wr, rd;
        write_en1 = w1; write_en2 = w2;
        write_inst1 = i1; write_addr1 = a1; write_inst2 = i2; write_addr2 = a2;
        read_en1 = r1; read_en2 = r2; flush = fl;
        @(posedge clk);
        n = sb.size();
        if (fl) begin
            sb.delete();
        end else begin
            wr = w1 ? (w2 ? 2 : 1) : 0;
            if (wr > DEPTH - n) wr = DEPTH - n;
            rd = r1 ? (r2 ? 2 : 1) : 0;
            if (rd > n) rd = n;
            for (int k = 0; k < rd; k++) void'(sb.pop_front());
            if (wr >= 1) sb.push_back({i1, a1});
            if (wr == 2) sb.push_back({i2, a2});
        end
        @(negedge clk);
        write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] pc;
        pc = 32'hbfc0_0000;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        check_all("post_reset");

        step("pair0", 1, 1, 32'h11111111, 32'hbfc00000, 32'h22222222, 32'hbfc00004, 0, 0, 0);
        chk("pair0.inst1_lit", read_inst1, 32'h11111111);
        chk("pair0.addr2_lit", read_addr2, 32'hbfc00004);
        step("drain0", 0, 0, 0, 0, 0, 0, 1, 1, 0);

        step("w2_only", 0, 1, 32'hdead0001, 32'h0, 32'hdead0002, 32'h4, 0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            step("fill", 1, 1, 32'ha000_0000 + c*2, pc, 32'ha000_0001 + c*2, pc + 4, 0, 0, 0);
            pc += 8;
        end
        chk("fill14.full", {31'd0, fifo_full}, 32'd0);
        step("fill16", 1, 1, 32'hb0000000, pc, 32'hb0000001, pc + 4, 0, 0, 0);
        pc += 8;
        chk("fill16.full", {31'd0, fifo_full}, 32'd1);
        step("drop", 1, 1, 32'hc0000000, pc, 32'hc0000001, pc + 4, 0, 0, 0);
        step("r2_only", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 7; c++) step("drain", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("pop1", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("cnt1.aempty", {31'd0, almost_empty}, 32'd1);
        step("rw_same", 1, 1, 32'hd0000000, 32'h100, 32'hd0000001, 32'h104, 1, 1, 0);
        chk("rw_same.inst1", read_inst1, 32'hd0000000);

        step("to5a", 1, 1, 32'he0, 32'h200, 32'he1, 32'h204, 0, 0, 0);
        step("to5b", 1, 0, 32'he2, 32'h208, 0, 0, 0, 0, 0);
        step("flush", 1, 0, 32'hf0, 32'h300, 0, 0, 1, 0, 1);
        chk("flush.inst1", read_inst1, 32'd0);

        step("wrap_pre", 1, 0, 32'h5000, 32'h400, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            step("wrap", 1, 1, $urandom, 32'h500 + c*8, $urandom, 32'h504 + c*8, 1, 1, 0);
        end
        for (int c = 0; c < 2; c++) step("wrap_drain", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("refill", 1, 1, 32'h6000, 32'h600, 32'h6001, 32'h604, 0, 0, 0);

        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("async_rst.empty", {31'd0, fifo_empty}, 32'd1);
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("after_rst", 1, 1, 32'h7000, 32'h700, 32'h7001, 32'h704, 0, 0, 0);
        step("after_rst_rd", 0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of entries; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all entries, driven on exception or branch redirect.
REQ-005 The block SHALL have ports write_en1 and write_en2, input, 1 bit each: slot 1 and slot 2 fetch data valid (inst_data_ok1/2).
REQ-006 The block SHALL have ports write_inst1 and write_inst2, input, 32 bits each: fetched instruction words.
REQ-007 The block SHALL have ports write_addr1 and write_addr2, input, 32 bits each: PC of each fetched word.
REQ-008 The block SHALL have ports read_en1 and read_en2, input, 1 bit each: decode consumes head entry / second entry this cycle.
REQ-009 The block SHALL have ports read_inst1 and read_inst2, output, 32 bits each: instruction at head and at head+1.
REQ-010 The block SHALL have ports read_addr1 and read_addr2, output, 32 bits each: PC at head and at head+1.
REQ-011 The block SHALL have port fifo_empty, output, 1 bit: count == 0.
REQ-012 The block SHALL have port almost_empty, output, 1 bit: count == 1.
REQ-013 The block SHALL have port fifo_full, output, 1 bit: fewer than 2 free slots, consumed combinationally by the PC stage.

Function
REQ-014 Storage SHALL be DEPTH entries of {inst, addr} with a write pointer, a read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and a count of log2(DEPTH)+1 bits.
REQ-015 fifo_full SHALL be asserted iff count > DEPTH-2; fifo_empty and almost_empty SHALL be decoded from count combinationally.
REQ-016 Writes accepted per cycle: write_en1 and write_en2 together = 2 (slot 1 at wptr, slot 2 at wptr+1); write_en1 alone = 1; write_en2 without write_en1 = 0 (ignored).
REQ-017 Accepted writes SHALL be capped by free space (DEPTH - count) measured before this cycle's reads; excess writes are dropped, slot 2 first.
REQ-018 Reads accepted per cycle: read_en1 and read_en2 together = min(2, count); read_en1 alone = min(1, count); read_en2 without read_en1 = 0.
REQ-019 Reads SHALL use the pre-edge count; a word written this cycle SHALL NOT be readable until the following cycle (no write-to-read bypass).
REQ-020 On each edge without flush: wptr += writes accepted, rptr += reads accepted, count += writes accepted - reads accepted.
REQ-021 read_inst1/read_addr1 SHALL show the entry at rptr when count >= 1, else 0; read_inst2/read_addr2 SHALL show the entry at rptr+1 (wrapped) when count >= 2, else 0.
REQ-022 flush SHALL take priority over all reads and writes in the same cycle: on the next edge wptr, rptr and count become 0, and all writes and reads that cycle are discarded.
REQ-023 Pointer wrap SHALL be seamless: a pair written at wptr = DEPTH-1 places slot 1 in entry DEPTH-1 and slot 2 in entry 0.

Reset
REQ-024 While rst is high, wptr, rptr and count SHALL be 0 asynchronously, giving fifo_empty=1, almost_empty=0, fifo_full=0 and all read_* outputs = 0.
REQ-025 Storage array contents SHALL NOT require reset; rst asserted mid-operation SHALL discard all entries, and after release the first write SHALL land in entry 0.

Verification
REQ-026 Reset, then write pair (0x11111111 @ 0xbfc00000, 0x22222222 @ 0xbfc00004) -> next cycle count=2, read_inst1=0x11111111, read_addr2=0xbfc00004, fifo_empty=0.
REQ-027 Dual-write 7 cycles with DEPTH=16 and no reads -> count=14, fifo_full=0; one more pair -> count=16, fifo_full=1; a further pair is dropped and count stays 16.
REQ-028 count=1 with read_en1=read_en2=1 and write pair in the same cycle -> one pop and two pushes, count=2; read outputs never show the same-cycle write data.
REQ-029 count=5 with flush=1, write_en1=1 and read_en1=1 -> next cycle count=0, fifo_empty=1, read_inst1=0.
REQ-030 Fill and drain across pointer wrap with pairs at wptr=15 -> entries read back in order with correct PCs; rst pulsed mid-stream -> fifo_empty=1 immediately, without waiting for a clock edge.
